// File: rtl/mul_sequencer_pkg.sv
// Shared types for the multiply sequencer: default word width and FSM state encoding.
package mul_sequencer_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'd0,
    MUL_ST_RUN  = 2'd1,
    MUL_ST_DONE = 2'd2
  } mul_st_e;

endpackage

// File: rtl/mul_sequencer.sv
// Shift-and-add MUL/MLA sequencer driving the parent's shared adder; low word of Rm*Rs (+Rn) with N/Z.
// Optional data-dependent latency when MUL_SEQ_EARLY_TERM_EN is defined.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             in_Clk,
  input  logic             in_Rst_n,
  input  logic             in_Start,
  input  logic             in_Accumulate,
  input  logic [WIDTH-1:0] in_Rm,
  input  logic [WIDTH-1:0] in_Rs,
  input  logic [WIDTH-1:0] in_Rn,
  input  logic [WIDTH-1:0] in_AddY,
  output logic             out_AddEn,
  output logic [WIDTH-1:0] out_AddA,
  output logic [WIDTH-1:0] out_AddB,
  output logic             out_AddCarry,
  output logic             out_Busy,
  output logic             out_Done,
  output logic [WIDTH-1:0] out_Result,
  output logic [1:0]       out_NZ
);

  localparam int CNT_W = $clog2(WIDTH);

  mul_st_e          state_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] m_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       nz_q;

  logic             run;
  logic             last_iter_d;
  logic [WIDTH-1:0] m_shift_d;

  assign run       = (state_q == MUL_ST_RUN);
  assign m_shift_d = m_q >> 1;

`ifdef MUL_SEQ_EARLY_TERM_EN
  assign last_iter_d = (cnt_q == CNT_W'(WIDTH - 1)) || (m_shift_d == '0);
`else
  assign last_iter_d = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  // Adder operands are forced to zero outside RUN so the parent mux sees a quiet bus.
  assign out_AddEn    = run;
  assign out_AddA     = run ? p_q : '0;
  assign out_AddB     = (run && m_q[0]) ? d_q : '0;
  assign out_AddCarry = 1'b0;
  assign out_Busy     = run;
  assign out_Done     = (state_q == MUL_ST_DONE);
  assign out_Result   = result_q;
  assign out_NZ       = nz_q;

  always_ff @(posedge in_Clk) begin
    if (!in_Rst_n) begin
      state_q  <= MUL_ST_IDLE;
      p_q      <= '0;
      d_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      nz_q     <= 2'b01;
    end else begin
      case (state_q)
        MUL_ST_IDLE: begin
          if (in_Start) begin
            p_q     <= in_Accumulate ? in_Rn : '0;
            d_q     <= in_Rm;
            m_q     <= in_Rs;
            cnt_q   <= '0;
            state_q <= MUL_ST_RUN;
          end
        end
        MUL_ST_RUN: begin
          p_q   <= in_AddY;
          d_q   <= d_q << 1;
          m_q   <= m_shift_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter_d) begin
            result_q <= in_AddY;
            nz_q     <= {in_AddY[WIDTH-1], (in_AddY == '0)};
            state_q  <= MUL_ST_DONE;
          end
        end
        MUL_ST_DONE: state_q <= MUL_ST_IDLE;
        default:     state_q <= MUL_ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle controller that executes ARM-style MUL/MLA by sequencing the shared 32-bit `adder` datapath as a shift-and-add multiplier. It sits beside the ALU in the execute stage. While busy it owns the adder's operand inputs through the parent's operand mux, and it returns the low word of Rm*Rs (+Rn) with N/Z flags. The adder is instantiated by the parent; this block only drives and samples it.

## Interface
- `WIDTH`, default `` `WordWidth `` (32): operand and result width.
- `in_Clk` input 1: clock; all state updates on the rising edge.
- `in_Rst_n` input 1: reset, synchronous, active-low.
- `in_Start` input 1: request; sampled only in IDLE.
- `in_Accumulate` input 1: 1 = MLA (add Rn), 0 = MUL; sampled with start.
- `in_Rm` input WIDTH: multiplicand; sampled with start.
- `in_Rs` input WIDTH: multiplier; sampled with start.
- `in_Rn` input WIDTH: accumulate operand; sampled with start.
- `in_AddY` input WIDTH: sum returned by the shared adder, combinational.
- `out_AddEn` output 1: adder ownership request to the parent operand mux.
- `out_AddA` output WIDTH: adder operand A.
- `out_AddB` output WIDTH: adder operand B.
- `out_AddCarry` output 1: adder carry-in; always 0.
- `out_Busy` output 1: high in RUN.
- `out_Done` output 1: one-cycle completion pulse.
- `out_Result` output WIDTH: registered product.
- `out_NZ` output 2: registered flags {N, Z} of the result.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: iterating over multiplier bits.
  - DONE: one-cycle completion.
- Internal registers:
  - P, WIDTH: partial product.
  - D, WIDTH: shifted multiplicand.
  - M, WIDTH: remaining multiplier.
  - cnt: iteration count, clog2(WIDTH) bits.
- IDLE with `in_Start`=1:
  - P ← `in_Accumulate` ? `in_Rn` : 0; D ← `in_Rm`; M ← `in_Rs`; cnt ← 0.
  - Next state RUN.
- RUN, each cycle:
  - Adder drive: A = P, B = M[0] ? D : 0, carry 0.
  - Register update: P ← `in_AddY`, D ← D<<1, M ← M>>1, cnt ← cnt+1.
- RUN exit to DONE on the same edge when cnt == WIDTH-1, or when early termination is enabled and (M>>1) == 0.
- Result computation: on the edge entering DONE, `out_Result` ← the final sum (`in_AddY`). N = sum[WIDTH-1]; Z = (sum == `` `WordZero ``).
- DONE: `out_Done`=1 for one cycle, then unconditionally back to IDLE.
- Arithmetic: modulo 2^WIDTH. Carry-out and overflow of each step are discarded. C and V are not produced; the parent keeps its C/V.
- Adder outputs when not in RUN: `out_AddEn`, `out_AddA`, `out_AddB` are 0.
- `in_Start` outside IDLE is ignored (no queuing). A start in the DONE cycle is lost, so the requester re-asserts it.
- `out_Result` and `out_NZ` hold their values until the next completion.
- Reset (`in_Rst_n`=0 at an edge), including mid-RUN:
  - State → IDLE; P, D, M, cnt cleared.
  - `out_Result`=0, `out_NZ`=2'b01, `out_Busy`=0, `out_Done`=0, `out_AddEn`=0.
  - Any partial operation is discarded.

## Timing
- `in_Start` sampled at edge t; RUN occupies edges t+1 onward.
- Without early termination: `out_Done` is high in the cycle after edge t+WIDTH. Latency is WIDTH+1 cycles (33 for WIDTH=32).
- With early termination: `out_Done` follows edge t+1+k, where k = index of the highest set bit of Rs (k=0 for Rs=0 or 1). Minimum 2 cycles; maximum WIDTH+1.
- Adder path: one combinational pass per cycle through a mux → adder → register loop.
- Throughput: one operation per latency+1 cycles, because the IDLE cycle is mandatory.

## Configuration
- `MUL_SEQ_EARLY_TERM_EN` defined: RUN exits as soon as the remaining multiplier is zero, giving data-dependent latency.
- Undefined: fixed WIDTH iterations. Results are identical either way; only latency differs.

## Structure
- Shared header `Def_StructureParameter.v`:
  - Uses the existing `` `WordWidth `` and `` `WordZero ``.
  - Adds state encodings `` `MulSt_Idle ``, `` `MulSt_Run ``, `` `MulSt_Done `` (2 bits).
- No sub-module. The adder stays a single shared instance in the parent, muxed by `out_AddEn`.

## Test plan
- MUL Rm=7, Rs=6 → `out_Result`=42, `out_NZ`=00. `out_Done` 33 cycles after start without the macro; 4 cycles after start with it (k=2).
- MLA Rm=3, Rs=5, Rn=10 → 25. Rs=0 with the macro → `out_Done` at start+2 and `out_Result`=Rn.
- MUL Rm=0xFFFFFFFF, Rs=0xFFFFFFFF → 0x00000001, N=0. Rm=0x80000000, Rs=1 → 0x80000000, `out_NZ`=10.
- MUL Rm=0x10000, Rs=0x10000 → 0 (wrap), `out_NZ`=01.
- Reset pulsed at RUN cycle 5 → IDLE next edge, all outputs at reset values. A new start then completes correctly.
- `in_Start` held high continuously → operations complete back-to-back, separated by exactly one IDLE cycle. A start during RUN/DONE does not alter the result.
